ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// then shifts one odd-parity command byte out on device clock falls.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int MAX_IR = (INHIBIT_CYCLES > REQ_CYCLES)
                        ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAXC   = (MAX_IR > TIMEOUT_CYCLES)
                        ? MAX_IR : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   frame_q, frame_d;
  logic          ack_q, ack_d;
  logic          tout_q, tout_d;
  logic [2:0]    clk_s_q, data_s_q;
  logic          fall, tmo, accept;

  // Idle bus reads high, so the synchronizers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s_q  <= 3'b111;
      data_s_q <= 3'b111;
    end else begin
      clk_s_q  <= {clk_s_q[1:0], ps2_clk};
      data_s_q <= {data_s_q[1:0], ps2_data};
    end
  end

  assign fall   = clk_s_q[2] & ~clk_s_q[1];
  assign tmo    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign accept = tx_valid & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      ack_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      ack_q   <= ack_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    ack_d       = ack_q;
    tout_d      = tout_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_INHIBIT;
          cnt_d   = '0;
          frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
          ack_d   = 1'b0;
          tout_d  = 1'b0;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (cnt_q == CW'(REQ_CYCLES - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (tmo) begin
          state_d = S_DONE;
          tout_d  = 1'b1;
          ack_d   = 1'b0;
        end else begin
          // frame_q[0] is the bit currently on the wire: start, data, parity, stop
          ps2_data_oe = ~frame_q[0];
          cnt_d       = cnt_q + CW'(1);
          if (fall) begin
            bit_d   = bit_q + 4'd1;
            frame_d = {1'b1, frame_q[10:1]};
            if (bit_q == 4'd10) begin
              ack_d   = ~data_s_q[1];
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (tmo) begin
          state_d = S_DONE;
          tout_d  = 1'b1;
          ack_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (clk_s_q[2] & data_s_q[2]) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign ack_ok      = ack_q;
  assign err_timeout = tout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on an open-drain bus plus
// a transfer-level scoreboard checked every cycle.
module tb_ps2_host_tx;

  localparam int INH   = 8;
  localparam int RQ    = 2;
  localparam int TMO   = 2000;
  localparam int M_ACK = 0;
  localparam int M_NAK = 1;
  localparam int M_SIL = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_ok, err_timeout;

  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  int          dev_mode = M_ACK;
  int          dev_k = 0;
  bit          dev_act = 1'b0;
  logic [10:0] dev_last = '0;
  logic [10:0] rxq[$];
  logic [7:0]  exp_b[$];
  int          exp_m[$];

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;
  bit   m_busy = 1'b0;
  bit   m_fin = 1'b0;
  logic m_ack = 1'b0;
  logic m_err = 1'b0;

  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (RQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Expected wire frame {stop, odd parity, data, start}
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    par = (ones % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic dwait(input int n, inout bit ab);
    repeat (n) begin
      @(posedge clk); #1;
      if (!resetn) ab = 1'b1;
    end
  endtask

  // Device: 20 clk high, sample data, 20 clk low; ACK held with the 11th low
  task automatic dev_frame();
    logic [10:0] f;
    bit          ab;
    f = '0;
    ab = 1'b0;
    dev_act = 1'b1;
    for (int k = 1; k <= 11 && !ab; k++) begin
      dwait(20, ab);
      if (!ab) begin
        f[k-1] = ps2_data;
        dev_clk_low = 1'b1;
        if (k == 11 && dev_mode == M_ACK) dev_data_low = 1'b1;
        dev_k = k;
        dwait(20, ab);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
      end
    end
    if (!ab) begin
      dev_last = f;
      rxq.push_back(f);
    end
    dev_k = 0;
    dev_act = 1'b0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (resetn && ps2_data_oe && !ps2_clk_oe && dev_mode != M_SIL)
      dev_frame();
  end

  // Scoreboard and per-cycle compare
  initial forever begin
    bit         acc;
    logic [7:0] b;
    int         md;
    @(posedge clk);
    acc = resetn && tx_valid && !m_busy;
    b   = tx_data;
    md  = dev_mode;
    #1;
    if (!resetn) begin
      m_busy = 1'b0; m_fin = 1'b0; m_ack = 1'b0; m_err = 1'b0;
      exp_b.delete(); exp_m.delete(); rxq.delete();
      chk("rst_oe", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ack", 32'(ack_ok), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
    end else begin
      if (m_fin) begin
        m_busy = 1'b0;
        m_fin = 1'b0;
      end
      if (acc) begin
        m_busy = 1'b1;
        m_ack = 1'b0;
        m_err = 1'b0;
        exp_b.push_back(b);
        exp_m.push_back(md);
        n_acc++;
      end
      chk("tx_ready", 32'(tx_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      if (done) begin
        chk("done_in_xfer", 32'(m_busy), 32'd1);
        if (exp_b.size() == 0) begin
          fail("done_unexpected");
        end else begin
          b  = exp_b.pop_front();
          md = exp_m.pop_front();
          m_ack = (md == M_ACK);
          m_err = (md == M_SIL);
          if (md != M_SIL) begin
            if (rxq.size() == 0) fail("frame_missing");
            else chk("frame", 32'(rxq.pop_front()), 32'(frame_of(b)));
          end
        end
        chk("done_ack", 32'(ack_ok), 32'(m_ack));
        chk("done_err", 32'(err_timeout), 32'(m_err));
        chk("done_oe", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);
        m_fin = 1'b1;
      end else if (!m_busy) begin
        chk("idle_oe", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);
        chk("idle_ack", 32'(ack_ok), 32'(m_ack));
        chk("idle_err", 32'(err_timeout), 32'(m_err));
      end
    end
  end

  task automatic wait_done(input int mx);
    int i;
    i = 0;
    while (!done && i < mx) begin
      @(posedge clk); #1;
      i++;
    end
    if (!done) fail("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input int md);
    dev_mode = md;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_done(3000);
  endtask

  initial begin
    int n1, n2, n3, base, i;
    repeat (4) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    send(8'hED, M_ACK);
    chk("t1_frame", 32'(dev_last), 32'(11'b11111011010));
    chk("t1_ack", 32'(ack_ok), 32'd1);
    chk("t1_err", 32'(err_timeout), 32'd0);

    send(8'h00, M_ACK);
    chk("t2_frame00", 32'(dev_last), 32'(11'b11000000000));
    chk("t2_ack00", 32'(ack_ok), 32'd1);
    send(8'hFF, M_ACK);
    chk("t2_frameFF", 32'(dev_last), 32'(11'b11111111110));
    chk("t2_ackFF", 32'(ack_ok), 32'd1);

    send(8'hA5, M_NAK);
    chk("t3_frame", 32'(dev_last), 32'(11'b11101001010));
    chk("t3_ack", 32'(ack_ok), 32'd0);
    chk("t3_err", 32'(err_timeout), 32'd0);

    dev_mode = M_SIL;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    n1 = 0;
    while (ps2_clk_oe && !ps2_data_oe && n1 < 100) begin
      n1++; @(posedge clk); #1;
    end
    n2 = 0;
    while (ps2_clk_oe && ps2_data_oe && n2 < 100) begin
      n2++; @(posedge clk); #1;
    end
    n3 = 0;
    while (!done && n3 < 3000) begin
      n3++; @(posedge clk); #1;
    end
    chk("t4_inhibit", 32'(n1), 32'd8);
    chk("t4_req", 32'(n2), 32'd2);
    chk("t4_release_to_done", 32'(n3), 32'd2000);
    chk("t4_err", 32'(err_timeout), 32'd1);
    chk("t4_ack", 32'(ack_ok), 32'd0);
    chk("t4_oe", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);
    @(posedge clk); #1;

    dev_mode = M_ACK;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    i = 0;
    while (dev_k < 4 && i < 2000) begin
      i++; @(posedge clk); #1;
    end
    if (dev_k < 4) fail("t5_reach_bit4");
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_oe", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);
    chk("t5_ready", 32'(tx_ready), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    i = 0;
    while (dev_act && i < 100) begin
      i++; @(posedge clk); #1;
    end
    @(posedge clk); #1;
    send(8'h55, M_ACK);
    chk("t5_frame55", 32'(dev_last), 32'(11'b11010101010));
    chk("t5_ack", 32'(ack_ok), 32'd1);

    base = n_acc;
    dev_mode = M_ACK;
    tx_data  = 8'h33;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hAA;
    i = 0;
    while (!done && i < 3000) begin
      i++; @(posedge clk); #1;
    end
    if (!done) fail("t6_first_done");
    tx_data = 8'h12;
    i = 0;
    @(posedge clk); #1;
    while (!busy && i < 10) begin
      i++; @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    wait_done(3000);
    chk("t6_frame12", 32'(dev_last), 32'(11'b11000100100));
    chk("t6_xfers", 32'(n_acc - base), 32'd2);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
